inst_fetch: RTL and testbench
=============================

Name: inst_fetch

Overview:
- Instruction-fetch sequencer directly downstream of the PC register.
- Takes the current PC, issues one request at a time on the SRAM-like instruction bus (req/addr_ok/data_ok) and advances the PC with a one-cycle enable pulse.
- Buffers the returned word and presents it to the IF/ID register with a valid flag, honouring the decode stall.
- On flush, drops any in-flight response so the PC register's redirect target is fetched next.

Parameters:
- WIDTH, 32, PC/address and instruction width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- pc_i  in  WIDTH  current PC from the PC register.
- pc_en_o  out  1  advance-PC pulse to the PC register's en.
- flush_i  in  1  redirect (exception/branch); the PC register loads its target on the same edge.
- id_stall_i  in  1  decode stage cannot accept an instruction.
- inst_req_o  out  1  bus request.
- inst_addr_o  out  WIDTH  bus address.
- inst_addr_ok_i  in  1  request accepted this cycle.
- inst_data_ok_i  in  1  read data valid this cycle.
- inst_rdata_i  in  WIDTH  read data.
- inst_valid_o  out  1  inst_o/pc_o valid for decode.
- inst_o  out  WIDTH  fetched instruction.
- pc_o  out  WIDTH  address of inst_o.
- adel_o  out  1  fetch address error (PC not word-aligned); qualified by inst_valid_o.

Behaviour:
- Reset (rst=0, async): state=IDLE; addr_q, inst_q, pc_q=0; kill_q=0; adel_q=0. All outputs are 0.
- States: IDLE, REQ, DATA, HOLD. At most one outstanding bus transaction.
- IDLE:
  - flush_i=1 -> stay IDLE.
  - pc_i[1:0]!=0 -> HOLD with inst_q=0, pc_q=pc_i, adel_q=1. No bus request, no pc_en_o.
  - Otherwise -> REQ with addr_q=pc_i.
- REQ:
  - inst_req_o=1, inst_addr_o=addr_q. The address stays stable until addr_ok.
  - addr_ok=1 -> DATA. pc_en_o = addr_ok & ~kill_q & ~flush_i (combinational, same cycle).
  - flush_i without addr_ok sets kill_q. The request stays asserted; it is never withdrawn.
  - flush_i together with addr_ok -> DATA with kill_q=1.
- DATA:
  - inst_req_o=0.
  - data_ok & (kill_q | flush_i) -> IDLE, data discarded, kill_q cleared.
  - data_ok otherwise -> HOLD with inst_q=inst_rdata_i, pc_q=addr_q, adel_q=0.
  - flush_i without data_ok sets kill_q; stay in DATA.
- HOLD:
  - inst_valid_o=1, inst_o=inst_q, pc_o=pc_q, adel_o=adel_q.
  - flush_i -> IDLE. Flush has priority over consumption.
  - else id_stall_i=0 -> consumed; adel_q cleared. If pc_i is aligned -> REQ with addr_q=pc_i; if misaligned -> stay HOLD, reloaded per the IDLE misaligned rule.
  - else stay HOLD with outputs unchanged.
- inst_valid_o is registered (state==HOLD), so there is no combinational path from the bus to decode.
- Minimum throughput: 3 cycles per instruction (REQ, DATA, HOLD) with zero-wait bus.
- Flush in IDLE/HOLD → (re)enter IDLE, so the next REQ picks up the redirected pc_i one cycle after the flush edge.
- Repeated flushes extend discard; kill_q is a single bit because only one transaction is outstanding.
- Bus slave shares rst. Reset mid-transaction abandons it with no discard bookkeeping.
- pc_en_o never pulses outside REQ, and never more than once per transaction.
- Misaligned PC with no flush: the misaligned word is re-presented after each consumption. The exception logic is responsible for flushing.

Decomposition:
- Shared cpu package: state encoding localparams (IDLE=2'd0, REQ=2'd1, DATA=2'd2, HOLD=2'd3) and the reset vector constant 32'hbfc00000, also used by the PC register.
- No sub-module. The FSM plus three data registers form one block.

Test Plan:
- Reset release, PC=bfc00000, zero-wait bus -> req/addr=bfc00000 on cycle 2; pc_en_o 1-cycle pulse with addr_ok; valid with inst_o=rdata, pc_o=bfc00000 two cycles later.
- addr_ok delayed 3 cycles -> inst_addr_o held at bfc00000 with req=1 for all 4 cycles; pc_en_o pulses exactly once.
- id_stall_i=1 for 5 cycles while in HOLD, bus drives a new rdata -> inst_o/pc_o unchanged, no new req until stall drops.
- flush_i in DATA, data_ok 2 cycles later with 0xDEADBEEF -> never valid; next req addr = redirect target (e.g. bfc00380); no pc_en_o for the killed fetch.
- flush_i coincident with addr_ok -> pc_en_o=0, response discarded, next fetch from the flush target.
- pc_i=bfc00002 -> no inst_req_o; inst_valid_o=1, adel_o=1, pc_o=bfc00002, inst_o=0.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
// Shared CPU definitions: fetch sequencer state encoding and the reset vector
// that both the PC register and the fetch unit start from.
package inst_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DATA = 2'd2,
        HOLD = 2'd3
    } fetch_state_e;

    localparam logic [31:0] RESET_VECTOR = 32'hbfc00000;

    function automatic logic word_aligned(input logic [1:0] lsb);
        return lsb == 2'b00;
    endfunction

endpackage

// File: rtl/inst_fetch.sv
// Instruction-fetch sequencer: one outstanding request on the SRAM-like bus,
// a one-word result buffer toward IF/ID, and flush-driven response discard.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pc_i,
    output logic             pc_en_o,
    input  logic             flush_i,
    input  logic             id_stall_i,
    output logic             inst_req_o,
    output logic [WIDTH-1:0] inst_addr_o,
    input  logic             inst_addr_ok_i,
    input  logic             inst_data_ok_i,
    input  logic [WIDTH-1:0] inst_rdata_i,
    output logic             inst_valid_o,
    output logic [WIDTH-1:0] inst_o,
    output logic [WIDTH-1:0] pc_o,
    output logic             adel_o
);

    fetch_state_e     state_q, state_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0] inst_q, inst_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic             kill_q, kill_d;
    logic             adel_q, adel_d;
    logic             pc_aligned;

    assign pc_aligned = word_aligned(pc_i[1:0]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            inst_q  <= '0;
            pc_q    <= '0;
            kill_q  <= 1'b0;
            adel_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            inst_q  <= inst_d;
            pc_q    <= pc_d;
            kill_q  <= kill_d;
            adel_q  <= adel_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        inst_d     = inst_q;
        pc_d       = pc_q;
        kill_d     = kill_q;
        adel_d     = adel_q;
        inst_req_o = 1'b0;
        pc_en_o    = 1'b0;

        case (state_q)
            IDLE: begin
                if (!flush_i) begin
                    if (!pc_aligned) begin
                        state_d = HOLD;
                        inst_d  = '0;
                        pc_d    = pc_i;
                        adel_d  = 1'b1;
                    end else begin
                        state_d = REQ;
                        addr_d  = pc_i;
                    end
                end
            end
            REQ: begin
                // Request is never withdrawn; a flush only marks the reply for discard.
                inst_req_o = 1'b1;
                pc_en_o    = inst_addr_ok_i & ~kill_q & ~flush_i;
                if (flush_i)
                    kill_d = 1'b1;
                if (inst_addr_ok_i)
                    state_d = DATA;
            end
            DATA: begin
                if (inst_data_ok_i) begin
                    if (kill_q || flush_i) begin
                        state_d = IDLE;
                        kill_d  = 1'b0;
                    end else begin
                        state_d = HOLD;
                        inst_d  = inst_rdata_i;
                        pc_d    = addr_q;
                        adel_d  = 1'b0;
                    end
                end else if (flush_i) begin
                    kill_d = 1'b1;
                end
            end
            HOLD: begin
                if (flush_i) begin
                    state_d = IDLE;
                    adel_d  = 1'b0;
                end else if (!id_stall_i) begin
                    adel_d = 1'b0;
                    if (pc_aligned) begin
                        state_d = REQ;
                        addr_d  = pc_i;
                    end else begin
                        // Misaligned PC is re-presented until exception logic flushes.
                        inst_d = '0;
                        pc_d   = pc_i;
                        adel_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign inst_addr_o  = addr_q;
    assign inst_valid_o = (state_q == HOLD);
    assign inst_o       = inst_q;
    assign pc_o         = pc_q;
    assign adel_o       = adel_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Randomized scoreboard bench for inst_fetch with a transaction-level bus/PC model.
`timescale 1ns/1ps
module tb_inst_fetch;
    import inst_fetch_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] pc;
    logic         pc_en;
    logic         flush;
    logic         id_stall;
    logic         inst_req;
    logic [W-1:0] inst_addr;
    logic         addr_ok;
    logic         data_ok;
    logic [W-1:0] inst_rdata;
    logic         inst_valid;
    logic [W-1:0] inst;
    logic [W-1:0] pc_out;
    logic         adel;
    logic [W-1:0] flush_target;

    always #5 clk = ~clk;

    inst_fetch #(.WIDTH(W)) dut (
        .clk           (clk),
        .rst           (rst),
        .pc_i          (pc),
        .pc_en_o       (pc_en),
        .flush_i       (flush),
        .id_stall_i    (id_stall),
        .inst_req_o    (inst_req),
        .inst_addr_o   (inst_addr),
        .inst_addr_ok_i(addr_ok),
        .inst_data_ok_i(data_ok),
        .inst_rdata_i  (inst_rdata),
        .inst_valid_o  (inst_valid),
        .inst_o        (inst),
        .pc_o          (pc_out),
        .adel_o        (adel)
    );

    // PC register environment: redirect on flush, +4 on the fetch unit's enable.
    always @(posedge clk or negedge rst) begin
        if (!rst)       pc <= RESET_VECTOR;
        else if (flush) pc <= flush_target;
        else if (pc_en) pc <= pc + 32'd4;
    end

    typedef struct packed {
        logic [W-1:0] inst;
        logic [W-1:0] pc;
        logic         adel;
    } exp_t;

    exp_t         q[$];
    int           n_cmp = 0;
    int           n_fail = 0;

    // Transaction-level model state
    bit           pending, txn_active, killed, stop_new, last_flush;
    int           dly, ok_pct, max_dly;
    logic [W-1:0] txn_addr, exp_fetch;

    function automatic logic [W-1:0] mem_word(input logic [W-1:0] a);
        return {a[15:0], a[31:16]} ^ 32'hc3a5_9e17;
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // fmode: 0 no flush, 1 flush, 2 flush only if requesting, 3 flush only while data pending
    task automatic step(input int fmode, input logic [W-1:0] tgt, input bit st);
        bit f;
        bit exp_pen;
        @(posedge clk);
        #1;
        case (fmode)
            1:       f = 1'b1;
            2:       f = inst_req;
            3:       f = pending;
            default: f = 1'b0;
        endcase
        last_flush   = f;
        flush        = f;
        flush_target = tgt;
        id_stall     = st;
        addr_ok      = inst_req && !stop_new && ($urandom_range(99) < ok_pct);
        data_ok      = pending && (dly == 0);
        inst_rdata   = data_ok ? mem_word(txn_addr) : $urandom;
        #1;
        if (inst_req) begin
            if (!txn_active) begin
                txn_active = 1'b1;
                killed     = 1'b0;
                txn_addr   = exp_fetch;
            end
            check("req_addr", inst_addr, txn_addr);
        end
        exp_pen = inst_req && addr_ok && !killed && !f;
        check("pc_en", {31'd0, pc_en}, {31'd0, exp_pen});
        if (exp_pen) exp_fetch = exp_fetch + 32'd4;
        if (data_ok) begin
            if (!(killed || f)) q.push_back('{inst: mem_word(txn_addr), pc: txn_addr, adel: 1'b0});
            pending    = 1'b0;
            txn_active = 1'b0;
        end else if (pending) begin
            dly--;
        end
        if (inst_req && addr_ok) begin
            pending = 1'b1;
            dly     = $urandom_range(max_dly);
        end
        if (txn_active && f) killed = 1'b1;
        if (f) exp_fetch = tgt;
    endtask

    task automatic rstep(input int fl_pct, input int st_pct);
        logic [W-1:0] tgt;
        tgt = {16'hbfc0, 16'($urandom) & 16'hfffc};
        step(($urandom_range(99) < fl_pct) ? 1 : 0, tgt, $urandom_range(99) < st_pct);
    endtask

    // Monitor: pops an expectation on each new presentation, checks stability while held.
    initial begin
        bit   prev_v, prev_st, prev_fl, holding;
        exp_t e, last;
        prev_v = 0; prev_st = 0; prev_fl = 0;
        last = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                holding = prev_v && prev_st && !prev_fl;
                if (inst_valid) begin
                    if (holding) begin
                        check("hold_inst", inst, last.inst);
                        check("hold_pc", pc_out, last.pc);
                        check("hold_adel", {31'd0, adel}, {31'd0, last.adel});
                    end else if (q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL unexpected_valid: got pc %h inst %h, expected no instruction", pc_out, inst);
                    end else begin
                        e = q.pop_front();
                        check("inst", inst, e.inst);
                        check("pc_o", pc_out, e.pc);
                        check("adel", {31'd0, adel}, {31'd0, e.adel});
                        last = e;
                    end
                end
                prev_v  = inst_valid;
                prev_st = id_stall;
                prev_fl = flush;
            end else begin
                prev_v = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        rst = 1'b0; flush = 1'b0; id_stall = 1'b0; addr_ok = 1'b0; data_ok = 1'b0;
        inst_rdata = '0; flush_target = '0;
        pending = 0; txn_active = 0; killed = 0; stop_new = 0; last_flush = 0;
        dly = 0; ok_pct = 100; max_dly = 0;
        txn_addr = '0; exp_fetch = RESET_VECTOR;

        #12;
        check("rst_req", {31'd0, inst_req}, 32'd0);
        check("rst_pc_en", {31'd0, pc_en}, 32'd0);
        check("rst_valid", {31'd0, inst_valid}, 32'd0);
        check("rst_addr", inst_addr, 32'd0);
        check("rst_inst", inst, 32'd0);
        check("rst_pc_o", pc_out, 32'd0);
        check("rst_adel", {31'd0, adel}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Zero-wait bus, no flush or stall
        for (int i = 0; i < 15; i++) step(0, '0, 1'b0);

        // Delayed addr_ok and response
        ok_pct = 30; max_dly = 3;
        for (int i = 0; i < 40; i++) step(0, '0, 1'b0);

        // Decode stall while holding: no new request
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            step(0, '0, 1'b1);
            found = inst_valid;
        end
        check("reach_hold", {31'd0, found}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            step(0, '0, 1'b1);
            check("stall_no_req", {31'd0, inst_req}, 32'd0);
        end

        // Flush while waiting for data
        ok_pct = 100; max_dly = 2;
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            step(3, 32'hbfc00380, 1'b0);
            found = last_flush;
        end
        check("flush_in_data", {31'd0, found}, 32'd1);
        for (int i = 0; i < 10; i++) step(0, '0, 1'b0);

        // Flush coincident with addr_ok
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            step(2, 32'hbfc00500, 1'b0);
            found = last_flush;
        end
        check("flush_with_addr_ok", {31'd0, found}, 32'd1);
        for (int i = 0; i < 10; i++) step(0, '0, 1'b0);

        // Misaligned redirect target
        ok_pct = 50; max_dly = 3;
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            step(0, '0, 1'b1);
            found = inst_valid;
        end
        check("reach_hold2", {31'd0, found}, 32'd1);
        step(1, 32'hbfc00002, 1'b1);
        q.push_back('{inst: '0, pc: 32'hbfc00002, adel: 1'b1});
        for (int i = 0; i < 4; i++) begin
            step(0, '0, 1'b1);
            check("adel_no_req", {31'd0, inst_req}, 32'd0);
        end
        q.push_back('{inst: '0, pc: 32'hbfc00002, adel: 1'b1});
        step(0, '0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(0, '0, 1'b1);
            check("adel_no_req2", {31'd0, inst_req}, 32'd0);
        end
        step(1, 32'hbfc00400, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) rstep(6, 30);
        ok_pct = 100; max_dly = 0;
        for (int i = 0; i < 100; i++) rstep(10, 20);

        // Drain: stop accepting new requests, let outstanding data land
        stop_new = 1;
        for (int i = 0; i < 12; i++) step(0, '0, 1'b0);
        n_cmp++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d instructions never presented, expected 0", q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
